ahb3lite_slave_mem: RTL and testbench

//  AHB-Lite word-wide memory slave downstream of the CPU/DMA master. It is the single slave on the bus.

---
 rtl/ahb3lite_pkg.sv | 48 ++++
 rtl/ahb_sram_word.sv | 42 ++++
 rtl/ahb3lite_slave_mem.sv | 197 +++++++++++++++++++
 tb/tb_ahb3lite_slave_mem.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb3lite_pkg.sv
// ---------------------------------------------------------------------------
// ahb3lite_pkg
// Purpose : Shared AHB-Lite bus types for the memory slave and its bench.
//           Holds the HTRANS/HRESP/HBURST encodings, the WORD size code and
//           the slave FSM state type.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } HTRANS_state;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } HRESP_state;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } HBURST_Type;

  // Only 32-bit transfers are legal on this slave.
  localparam logic [2:0] WORD = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } slave_state;

  // NONSEQ and SEQ are the only transfer types that carry a real transfer.
  function automatic logic is_transfer(input HTRANS_state t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/ahb_sram_word.sv
// ---------------------------------------------------------------------------
// ahb_sram_word
// Purpose : 2**ADDR_W x 32 word memory with one synchronous write port,
//           one combinational bus read port and one combinational debug
//           read port. Contents are never cleared by reset.
// Ports   :
//   i_clk       in   1       write clock
//   i_we        in   1       write enable
//   i_waddr     in   ADDR_W  write word index
//   i_wdata     in   32      write data
//   i_raddr     in   ADDR_W  bus read word index
//   o_rdata     out  32      mem[i_raddr], combinational
//   i_dbg_addr  in   ADDR_W  debug read word index
//   o_dbg_data  out  32      mem[i_dbg_addr], combinational
// ---------------------------------------------------------------------------
module ahb_sram_word #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic [31:0]       o_dbg_data
);

  logic [31:0] r_mem [2**ADDR_W];

  // Single write port; reads below see the old word until this edge lands,
  // which is what gives the debug port its read-old-data behaviour.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata    = r_mem[i_raddr];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/ahb3lite_slave_mem.sv
// ---------------------------------------------------------------------------
// ahb3lite_slave_mem
// Purpose : AHB-Lite word-wide memory slave. Accepts pipelined NONSEQ/SEQ
//           read and write transfers addressed by word index, inserts
//           optional wait states, returns the two-cycle ERROR response for
//           illegal transfers and exposes a side debug read port.
// Build option:
//   AHB_SLV_WAIT_EN  defined   -> i_wait_n wait cycles per legal transfer
//                    undefined -> every legal transfer is zero-wait
// Ports   :
//   HCLK        in   1             bus clock
//   HRESET      in   1             synchronous active-high reset
//   HSEL        in   1             slave select
//   HADDR       in   32            word index
//   HWRITE      in   1             1 = write
//   HSIZE       in   3             transfer size, WORD only
//   HBURST      in   HBURST_Type   burst type (not checked)
//   HTRANS      in   HTRANS_state  transfer type
//   HWDATA      in   32            write data (data phase)
//   HRDATA      out  32            read data, valid while HREADY=1
//   HREADY      out  1             ready
//   HRESP       out  HRESP_state   OKAY/ERROR
//   i_wait_n    in   WAIT_W        wait states per transfer
//   i_dbg_addr  in   ADDR_W        debug read index
//   o_dbg_data  out  32            mem[i_dbg_addr]
// ---------------------------------------------------------------------------
module ahb3lite_slave_mem
  import ahb3lite_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WAIT_W = 3
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  HBURST_Type        HBURST,
  input  HTRANS_state       HTRANS,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADY,
  output HRESP_state        HRESP,
  input  logic [WAIT_W-1:0] i_wait_n,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic [31:0]       o_dbg_data
);

  slave_state        r_state;
  logic              r_hready;
  HRESP_state        r_hresp;
  logic [31:0]       r_hrdata;
  logic              r_active;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
`ifdef AHB_SLV_WAIT_EN
  logic [WAIT_W-1:0] r_wcnt;
`endif

  logic              w_accept;
  logic              w_illegal;
  logic              w_complete;
  logic              w_we;
  logic              w_bypass;
  logic [ADDR_W-1:0] w_addr_idx;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [31:0]       w_rd_data;
  logic              w_unused_in;

  // HBURST is informational only; in the zero-wait build i_wait_n is too.
`ifdef AHB_SLV_WAIT_EN
  assign w_unused_in = ^HBURST;
`else
  assign w_unused_in = ^{HBURST, i_wait_n};
`endif

  assign w_addr_idx = HADDR[ADDR_W-1:0];

  // HREADY is always high in S_IDLE, and S_ERR2 is deliberately excluded so
  // the transfer the master cancels after an ERROR is dropped.
  assign w_accept   = (r_state == S_IDLE) && r_hready && HSEL && is_transfer(HTRANS);
  assign w_illegal  = (HSIZE != WORD) || (HADDR[31:ADDR_W] != '0);

  // A legal data phase ends on any edge where it sees HREADY high.
  assign w_complete = (r_state == S_IDLE) && r_hready && r_active;

  // Reset on the completing edge throws the pending write away.
  assign w_we       = w_complete && r_write && !HRESET;

  // Back-to-back write then read of the same word: the memory is only
  // updated on this very edge, so forward the bus write data instead.
  assign w_bypass   = w_we && (r_addr == w_addr_idx);

`ifdef AHB_SLV_WAIT_EN
  assign w_rd_addr = (r_state == S_WAIT) ? r_addr : w_addr_idx;
`else
  assign w_rd_addr = w_addr_idx;
`endif

  ahb_sram_word #(
    .ADDR_W (ADDR_W)
  ) u_sram (
    .i_clk      (HCLK),
    .i_we       (w_we),
    .i_waddr    (r_addr),
    .i_wdata    (HWDATA),
    .i_raddr    (w_rd_addr),
    .o_rdata    (w_rd_data),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data)
  );

  // Slave FSM. All bus outputs are registered here so that HREADY, HRESP
  // and HRDATA change only on HCLK edges. Read data is loaded on the edge
  // that starts the HREADY=1 cycle of the data phase: the accepting edge
  // for zero-wait reads, the last wait edge otherwise.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state  <= S_IDLE;
      r_hready <= 1'b1;
      r_hresp  <= OKAY;
      r_hrdata <= '0;
      r_active <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
`ifdef AHB_SLV_WAIT_EN
      r_wcnt   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_hready <= 1'b1;
          r_hresp  <= OKAY;
          if (w_complete) begin
            r_active <= 1'b0;
          end
          if (w_accept) begin
            r_addr  <= w_addr_idx;
            r_write <= HWRITE;
            if (w_illegal) begin
              r_active <= 1'b0;
              r_state  <= S_ERR1;
              r_hready <= 1'b0;
              r_hresp  <= ERROR;
            end else begin
              r_active <= 1'b1;
`ifdef AHB_SLV_WAIT_EN
              if (i_wait_n != '0) begin
                r_state  <= S_WAIT;
                r_hready <= 1'b0;
                r_wcnt   <= i_wait_n - WAIT_W'(1);
              end else
`endif
              if (!HWRITE) begin
                r_hrdata <= w_bypass ? HWDATA : w_rd_data;
              end
            end
          end
        end
`ifdef AHB_SLV_WAIT_EN
        S_WAIT: begin
          if (r_wcnt == '0) begin
            r_state  <= S_IDLE;
            r_hready <= 1'b1;
            if (!r_write) begin
              r_hrdata <= w_rd_data;
            end
          end else begin
            r_wcnt <= r_wcnt - WAIT_W'(1);
          end
        end
`endif
        S_ERR1: begin
          r_state  <= S_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= ERROR;
        end
        S_ERR2: begin
          r_state  <= S_IDLE;
          r_hready <= 1'b1;
          r_hresp  <= OKAY;
        end
        default: begin
          r_state  <= S_IDLE;
          r_hready <= 1'b1;
          r_hresp  <= OKAY;
        end
      endcase
    end
  end

  assign HRDATA = r_hrdata;
  assign HREADY = r_hready;
  assign HRESP  = r_hresp;

endmodule

// File: tb/tb_ahb3lite_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_ahb3lite_slave_mem
// Purpose : Self-checking bench for ahb3lite_slave_mem. A small pipelined
//           master drives beat tables; read expectations come from a
//           reference memory and are queued when the read address phase is
//           driven, then popped when the data phase completes.
// Build option: AHB_SLV_WAIT_EN selects the wait-state expectations.
// ---------------------------------------------------------------------------
module tb_ahb3lite_slave_mem;
  import ahb3lite_pkg::*;

  localparam int ADDR_W = 8;
  localparam int WAIT_W = 3;
`ifdef AHB_SLV_WAIT_EN
  localparam int WAIT_ON = 1;
`else
  localparam int WAIT_ON = 0;
`endif

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic              HSEL;
  logic [31:0]       HADDR;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  HBURST_Type        HBURST;
  HTRANS_state       HTRANS;
  logic [31:0]       HWDATA;
  logic [31:0]       HRDATA;
  logic              HREADY;
  HRESP_state        HRESP;
  logic [WAIT_W-1:0] i_wait_n;
  logic [ADDR_W-1:0] i_dbg_addr;
  logic [31:0]       o_dbg_data;

  int nChecks = 0;
  int nFail   = 0;
  int waitCycles;
  int respBad;

  logic [31:0] model [256];
  logic [31:0] expQ [$];

  HTRANS_state bTrans [32];
  logic [31:0] bAddr  [32];
  logic        bWrite [32];
  logic [31:0] bData  [32];
  int          nBeats = 0;

  ahb3lite_slave_mem #(
    .ADDR_W (ADDR_W),
    .WAIT_W (WAIT_W)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HSEL       (HSEL),
    .HADDR      (HADDR),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HBURST     (HBURST),
    .HTRANS     (HTRANS),
    .HWDATA     (HWDATA),
    .HRDATA     (HRDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .i_wait_n   (i_wait_n),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data)
  );

  // Free-running bus clock, 10 time units per period.
  always #5 HCLK = ~HCLK;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Puts one address phase on the bus.
  task automatic applyStimulus(input HTRANS_state t, input logic [31:0] a, input logic w, input logic [2:0] s);
    HSEL   = 1'b1;
    HTRANS = t;
    HADDR  = a;
    HWRITE = w;
    HSIZE  = s;
  endtask

  task automatic addBeat(input HTRANS_state t, input logic [31:0] a, input logic w, input logic [31:0] d);
    bTrans[nBeats] = t;
    bAddr[nBeats]  = a;
    bWrite[nBeats] = w;
    bData[nBeats]  = d;
    nBeats++;
  endtask

  function automatic logic [31:0] popExp();
    if (expQ.size() == 0) return 32'hBAD0_0000;
    return expQ.pop_front();
  endfunction

  task automatic checkMem(input logic [7:0] idx, input string tag);
    i_dbg_addr = idx;
    #1;
    checkOutput(tag, o_dbg_data, model[idx]);
  endtask

  // Pipelined master over the beat table. Each loop pass is one bus cycle,
  // entered just after a rising edge. A beat driven in a cycle with HREADY
  // high is accepted at the next edge; its data phase ends on the first
  // later cycle that shows HREADY high.
  task automatic runBeats(input string tag);
    int   ap = 0;
    int   cur = -1;
    int   dp = -1;
    int   guard = 0;
    logic prevReady = 1'b1;
    logic ready;
    waitCycles = 0;
    respBad    = 0;
    @(posedge HCLK); #1;
    forever begin
      if (prevReady) begin
        dp  = (cur >= 0 && (bTrans[cur] == NONSEQ || bTrans[cur] == SEQ)) ? cur : -1;
        cur = -1;
      end
      if (ap >= nBeats && cur < 0 && dp < 0) break;
      guard++;
      if (guard > 200) begin
        checkOutput({tag, " timeout"}, 32'(guard), 32'd0);
        break;
      end
      HWDATA = (dp >= 0 && bWrite[dp]) ? bData[dp] : 32'h0;
      if (HRESP != OKAY) respBad++;
      ready = HREADY;
      if (ready) begin
        if (dp >= 0 && !bWrite[dp]) checkOutput({tag, " rdata"}, HRDATA, popExp());
        if (ap < nBeats) begin
          applyStimulus(bTrans[ap], bAddr[ap], bWrite[ap], WORD);
          if (bTrans[ap] == NONSEQ || bTrans[ap] == SEQ) begin
            if (bWrite[ap]) model[bAddr[ap][7:0]] = bData[ap];
            else expQ.push_back(model[bAddr[ap][7:0]]);
          end
          cur = ap;
          ap++;
        end else begin
          applyStimulus(IDLE, 32'h0, 1'b0, WORD);
        end
      end else begin
        waitCycles++;
      end
      prevReady = ready;
      @(posedge HCLK); #1;
    end
    HWDATA = 32'h0;
    checkOutput({tag, " okay"}, 32'(respBad), 32'd0);
    nBeats = 0;
  endtask

  // Illegal transfer: two ERROR cycles, the transfer offered during the
  // second one must be dropped, and memory must stay untouched.
  task automatic errorCase(input logic [31:0] a, input logic [2:0] s, input string tag);
    @(posedge HCLK); #1;
    applyStimulus(NONSEQ, a, 1'b1, s);
    @(posedge HCLK); #1;
    HWDATA = 32'hDEAD_BEEF;
    applyStimulus(IDLE, 32'h0, 1'b0, WORD);
    checkOutput({tag, " err1 hready"}, 32'(HREADY), 32'd0);
    checkOutput({tag, " err1 hresp"}, 32'(HRESP), 32'(ERROR));
    @(posedge HCLK); #1;
    checkOutput({tag, " err2 hready"}, 32'(HREADY), 32'd1);
    checkOutput({tag, " err2 hresp"}, 32'(HRESP), 32'(ERROR));
    applyStimulus(NONSEQ, 32'h0, 1'b1, WORD);
    @(posedge HCLK); #1;
    HWDATA = 32'h0BAD_0BAD;
    applyStimulus(IDLE, 32'h0, 1'b0, WORD);
    checkOutput({tag, " after hready"}, 32'(HREADY), 32'd1);
    checkOutput({tag, " after hresp"}, 32'(HRESP), 32'(OKAY));
    @(posedge HCLK); #1;
    HWDATA = 32'h0;
    checkMem(a[7:0], {tag, " mem target"});
    checkMem(8'h00, {tag, " mem dropped"});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int low;
    HRESET     = 1'b1;
    HSEL       = 1'b0;
    HTRANS     = IDLE;
    HADDR      = 32'h0;
    HWRITE     = 1'b0;
    HSIZE      = WORD;
    HBURST     = SINGLE;
    HWDATA     = 32'h0;
    i_wait_n   = 3'd0;
    i_dbg_addr = 8'h0;

    // Reset state
    repeat (2) @(posedge HCLK);
    #1;
    checkOutput("reset hready", 32'(HREADY), 32'd1);
    checkOutput("reset hresp", 32'(HRESP), 32'(OKAY));
    checkOutput("reset hrdata", HRDATA, 32'h0);
    HRESET = 1'b0;

    // Single write then back-to-back read of the same word (bypass)
    $display("[TB] single write/read");
    addBeat(NONSEQ, 32'h10, 1'b1, 32'hA5A5_0001);
    addBeat(NONSEQ, 32'h10, 1'b0, 32'h0);
    runBeats("t2");
    checkOutput("t2 waits", 32'(waitCycles), 32'd0);
    checkMem(8'h10, "t2 dbg");

    // Decrementing INCR4 with a BUSY cycle; the BUSY beat aims at 0x30
    $display("[TB] INCR4 with BUSY");
    addBeat(NONSEQ, 32'h30, 1'b1, 32'h3030_3030);
    runBeats("t3pre");
    HBURST = INCR4;
    addBeat(NONSEQ, 32'h23, 1'b1, 32'hD000_0000);
    addBeat(SEQ,    32'h22, 1'b1, 32'hD000_0001);
    addBeat(BUSY,   32'h30, 1'b1, 32'hFFFF_FFFF);
    addBeat(SEQ,    32'h21, 1'b1, 32'hD000_0002);
    addBeat(SEQ,    32'h20, 1'b1, 32'hD000_0003);
    runBeats("t3w");
    for (int i = 32; i < 36; i++) checkMem(8'(i), "t3 dbg");
    checkMem(8'h30, "t3 busy");
    HBURST = INCR;
    for (int i = 0; i < 4; i++) addBeat(i == 0 ? NONSEQ : SEQ, 32'h20 + 32'(i), 1'b0, 32'h0);
    runBeats("t3r");

    // Wait states on a single write, then on a read
    $display("[TB] wait states");
    HBURST = SINGLE;
    addBeat(NONSEQ, 32'h50, 1'b1, 32'h5050_0000);
    runBeats("t4pre");
    @(posedge HCLK); #1;
    i_wait_n = 3'd3;
    applyStimulus(NONSEQ, 32'h50, 1'b1, WORD);
    @(posedge HCLK); #1;
    HWDATA = 32'h5050_0004;
    applyStimulus(IDLE, 32'h0, 1'b0, WORD);
    low = 0;
    while (HREADY == 1'b0 && low < 10) begin
      low++;
      @(posedge HCLK); #1;
    end
    checkOutput("t4 low cycles", 32'(low), WAIT_ON != 0 ? 32'd3 : 32'd0);
    checkMem(8'h50, "t4 before write edge");
    @(posedge HCLK); #1;
    HWDATA = 32'h0;
    model[8'h50] = 32'h5050_0004;
    checkMem(8'h50, "t4 after write edge");
    i_wait_n = 3'd2;
    addBeat(NONSEQ, 32'h50, 1'b0, 32'h0);
    runBeats("t4r");
    checkOutput("t4 read waits", 32'(waitCycles), WAIT_ON != 0 ? 32'd2 : 32'd0);
    i_wait_n = 3'd0;

    // ERROR response for out-of-range index and for a non-word size
    $display("[TB] error responses");
    addBeat(NONSEQ, 32'h00, 1'b1, 32'h1234_5678);
    addBeat(NONSEQ, 32'h05, 1'b1, 32'h0505_0505);
    runBeats("t5pre");
    errorCase(32'h0000_0100, WORD, "t5 addr");
    errorCase(32'h0000_0005, 3'b001, "t5 size");
    addBeat(NONSEQ, 32'h06, 1'b1, 32'h0606_0606);
    addBeat(NONSEQ, 32'h06, 1'b0, 32'h0);
    runBeats("t5 next");

    // Reset during the second beat of an INCR8
    $display("[TB] reset mid-burst");
    HBURST = INCR8;
    for (int i = 0; i < 8; i++) addBeat(i == 0 ? NONSEQ : SEQ, 32'h40 + 32'(i), 1'b1, 32'h0FF0_0000 + 32'(i));
    runBeats("t6pre");
    @(posedge HCLK); #1;
    applyStimulus(NONSEQ, 32'h40, 1'b1, WORD);
    @(posedge HCLK); #1;
    HWDATA = 32'h6000_0000;
    applyStimulus(SEQ, 32'h41, 1'b1, WORD);
    @(posedge HCLK); #1;
    HWDATA = 32'h6000_0001;
    applyStimulus(SEQ, 32'h42, 1'b1, WORD);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    HWDATA = 32'h0;
    applyStimulus(IDLE, 32'h0, 1'b0, WORD);
    model[8'h40] = 32'h6000_0000;
    checkOutput("t6 hready", 32'(HREADY), 32'd1);
    checkOutput("t6 hresp", 32'(HRESP), 32'(OKAY));
    checkOutput("t6 hrdata", HRDATA, 32'h0);
    checkMem(8'h40, "t6 beat1");
    checkMem(8'h41, "t6 beat2 dropped");
    checkMem(8'h42, "t6 beat3");
    for (int i = 0; i < 8; i++) addBeat(i == 0 ? NONSEQ : SEQ, 32'h47 - 32'(i), 1'b1, 32'h7700_0000 + 32'(i));
    for (int i = 0; i < 8; i++) addBeat(i == 0 ? NONSEQ : SEQ, 32'h40 + 32'(i), 1'b0, 32'h0);
    runBeats("t6 fresh");
    checkMem(8'h43, "t6 fresh dbg");

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
